// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART/ALU frame sequencer: state encoding,
// default widths and protocol bytes.
package uart_alu_pkg;

    localparam int          DATA_W_DEF  = 8;
    localparam int          OP_W_DEF    = 6;
    localparam logic [7:0]  SYNC_DEF    = 8'hA5;
    localparam logic [7:0]  ACK_DEF     = 8'h06;
    localparam logic [7:0]  NAK_DEF     = 8'h15;
    localparam int          TIMEOUT_DEF = 50000;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_GET_A     = 4'd1,
        ST_GET_B     = 4'd2,
        ST_GET_OP    = 4'd3,
        ST_GET_CHK   = 4'd4,
        ST_EXEC      = 4'd5,
        ST_TX_RES    = 4'd6,
        ST_WAIT_RES  = 4'd7,
        ST_TX_STAT   = 4'd8,
        ST_WAIT_STAT = 4'd9
    } state_e;

    // Frame-collection states are the only ones guarded by the inter-byte timeout.
    function automatic logic is_get_state(input state_e s);
        return (s == ST_GET_A) || (s == ST_GET_B) || (s == ST_GET_OP) || (s == ST_GET_CHK);
    endfunction

endpackage

// File: rtl/frame_timeout_cnt.sv
// Inter-byte timeout counter: cleared by clear, counts while enabled,
// flags expiry on the last allowed cycle unless a clear arrives in that cycle.
module frame_timeout_cnt #(
    parameter int TIMEOUT = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int               CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear has priority over counting.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (enable) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = enable && !clear && (cnt_q == LAST);

endmodule

// File: rtl/uart_alu_frame_ctrl.sv
// Framed command sequencer: collects SYNC,A,B,OP,CHK from the UART RX, drives the
// ALU once the frame validates and returns result + ACK (or a lone NAK) via UART TX.
module uart_alu_frame_ctrl
    import uart_alu_pkg::*;
#(
    parameter int                DATA_W    = DATA_W_DEF,
    parameter int                OP_W      = OP_W_DEF,
    parameter logic [DATA_W-1:0] SYNC_BYTE = SYNC_DEF,
    parameter logic [DATA_W-1:0] ACK_BYTE  = ACK_DEF,
    parameter logic [DATA_W-1:0] NAK_BYTE  = NAK_DEF,
    parameter int                TIMEOUT   = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_rx_done,
    input  logic [DATA_W-1:0] i_rx,
    input  logic              i_tx_done,
    input  logic [DATA_W-1:0] i_alu_result,
    output logic              o_tx_start,
    output logic [DATA_W-1:0] o_tx,
    output logic [DATA_W-1:0] o_alu_a,
    output logic [DATA_W-1:0] o_alu_b,
    output logic [OP_W-1:0]   o_alu_opcode,
    output logic              o_busy,
    output logic              o_err
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, op_q, op_d, res_q, res_d, stat_q, stat_d;
    logic [DATA_W-1:0] tx_q, tx_d, alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [OP_W-1:0]   alu_op_q, alu_op_d;
    logic              tx_start_q, tx_start_d, busy_q, busy_d, err_q, err_d;
    logic              guard_q, guard_d;
    logic              expire_s, chk_ok_s, op_ok_s;

    frame_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (i_rx_done),
        .enable (is_get_state(state_q)),
        .expire (expire_s)
    );

    assign chk_ok_s = (i_rx == (a_q ^ b_q ^ op_q));
    assign op_ok_s  = (op_q[DATA_W-1:OP_W] == {(DATA_W-OP_W){1'b0}});

    // Next-state and datapath: everything is held unless a state explicitly updates it.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        res_d      = res_q;
        stat_d     = stat_q;
        tx_d       = tx_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        guard_d    = guard_q;
        tx_start_d = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_rx_done && (i_rx == SYNC_BYTE)) begin
                    state_d = ST_GET_A;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GET_A, ST_GET_B, ST_GET_OP: begin
                if (i_rx_done) begin
                    if (state_q == ST_GET_A) begin
                        a_d     = i_rx;
                        state_d = ST_GET_B;
                    end else if (state_q == ST_GET_B) begin
                        b_d     = i_rx;
                        state_d = ST_GET_OP;
                    end else begin
                        op_d    = i_rx;
                        state_d = ST_GET_CHK;
                    end
                end else if (expire_s) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            ST_GET_CHK: begin
                if (i_rx_done) begin
                    if (chk_ok_s && op_ok_s) begin
                        alu_a_d  = a_q;
                        alu_b_d  = b_q;
                        alu_op_d = op_q[OP_W-1:0];
                        stat_d   = ACK_BYTE;
                        state_d  = ST_EXEC;
                    end else begin
                        stat_d   = NAK_BYTE;
                        err_d    = 1'b1;
                        state_d  = ST_TX_STAT;
                    end
                end else if (expire_s) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GET_CHK;
                end
            end
            ST_EXEC: begin
                res_d   = i_alu_result;
                state_d = ST_TX_RES;
            end
            ST_TX_RES, ST_TX_STAT: begin
                if (i_tx_done) begin
                    tx_start_d = 1'b1;
                    tx_d       = (state_q == ST_TX_RES) ? res_q : stat_q;
                    guard_d    = 1'b1;
                    state_d    = (state_q == ST_TX_RES) ? ST_WAIT_RES : ST_WAIT_STAT;
                end else begin
                    state_d = state_q;
                end
            end
            // The transmitter may not drop tx_done until a cycle after the start pulse.
            ST_WAIT_RES, ST_WAIT_STAT: begin
                if (guard_q) begin
                    guard_d = 1'b0;
                    state_d = state_q;
                end else if (i_tx_done) begin
                    state_d = (state_q == ST_WAIT_RES) ? ST_TX_STAT : ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State, frame and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            a_q        <= {DATA_W{1'b0}};
            b_q        <= {DATA_W{1'b0}};
            op_q       <= {DATA_W{1'b0}};
            res_q      <= {DATA_W{1'b0}};
            stat_q     <= {DATA_W{1'b0}};
            tx_q       <= {DATA_W{1'b0}};
            alu_a_q    <= {DATA_W{1'b0}};
            alu_b_q    <= {DATA_W{1'b0}};
            alu_op_q   <= {OP_W{1'b0}};
            guard_q    <= 1'b0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            res_q      <= res_d;
            stat_q     <= stat_d;
            tx_q       <= tx_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            guard_q    <= guard_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign o_tx_start   = tx_start_q;
    assign o_tx         = tx_q;
    assign o_alu_a      = alu_a_q;
    assign o_alu_b      = alu_b_q;
    assign o_alu_opcode = alu_op_q;
    assign o_busy       = busy_q;
    assign o_err        = err_q;

endmodule

// File: tb/tb_uart_alu_frame_ctrl.sv
// Directed bench for uart_alu_frame_ctrl with a small reference ALU and TX/err logging.
module tb_uart_alu_frame_ctrl;

    localparam int TO = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_done = 1'b0;
    logic [7:0] rx = 8'h00;
    logic       tx_done = 1'b1;
    logic [7:0] alu_result;
    logic       tx_start;
    logic [7:0] tx;
    logic [7:0] alu_a, alu_b;
    logic [5:0] alu_op;
    logic       busy, err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_rx_cyc = 0;
    int err_cnt  = 0;
    logic [7:0] tx_log[$];
    int         tx_cyc[$];

    uart_alu_frame_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .i_rx_done(rx_done), .i_rx(rx), .i_tx_done(tx_done),
        .i_alu_result(alu_result), .o_tx_start(tx_start), .o_tx(tx), .o_alu_a(alu_a),
        .o_alu_b(alu_b), .o_alu_opcode(alu_op), .o_busy(busy), .o_err(err)
    );

    always #5 clk = ~clk;

    // Reference ALU: 0x20 ADD, 0x22 SUB, anything else AND.
    always_comb begin
        case (alu_op)
            6'h20:   alu_result = alu_a + alu_b;
            6'h22:   alu_result = alu_a - alu_b;
            default: alu_result = alu_a & alu_b;
        endcase
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_start === 1'b1) begin
            tx_log.push_back(tx);
            tx_cyc.push_back(cyc);
        end
        if (err === 1'b1) err_cnt++;
    end

    task automatic clear_logs();
        tx_log.delete();
        tx_cyc.delete();
        err_cnt = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx = b;
        rx_done = 1'b1;
        last_rx_cyc = cyc;
        @(posedge clk); #1;
        rx_done = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] op, input logic [7:0] chk);
        send_byte(8'hA5);
        send_byte(a);
        send_byte(b);
        send_byte(op);
        send_byte(chk);
    endtask

    task automatic wait_idle(input string name);
        int i;
        for (i = 0; i < 100; i++) begin
            if (busy === 1'b0) break;
            @(posedge clk); #1;
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s wait_idle: busy=%b after 100 cycles, required 0", name, busy);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_add_frame(input string name);
        clear_logs();
        send_frame(8'h0A, 8'h14, 8'h20, 8'h3E);
        wait_idle(name);
        n_checks++;
        if (alu_a !== 8'h0A || alu_b !== 8'h14 || alu_op !== 6'h20) begin
            n_fail++;
            $display("FAIL %s alu regs: got a=%h b=%h op=%h, required 0a 14 20", name, alu_a, alu_b, alu_op);
        end
        n_checks++;
        if (tx_log.size() != 2) begin
            n_fail++;
            $display("FAIL %s tx count: got %0d, required 2", name, tx_log.size());
        end else begin
            n_checks++;
            if (tx_log[0] !== 8'h1E || tx_log[1] !== 8'h06) begin
                n_fail++;
                $display("FAIL %s tx bytes: got %h %h, required 1e 06", name, tx_log[0], tx_log[1]);
            end
        end
        n_checks++;
        if (err_cnt != 0) begin
            n_fail++;
            $display("FAIL %s err: got %0d pulses, required 0", name, err_cnt);
        end
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (tx_start !== 1'b0 || tx !== 8'h00 || alu_a !== 8'h00 || alu_b !== 8'h00 ||
            alu_op !== 6'h00 || busy !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset outputs: got start=%b tx=%h a=%h b=%h op=%h busy=%b err=%b, required all 0",
                     tx_start, tx, alu_a, alu_b, alu_op, busy, err);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_valid_frame();
        check_add_frame("valid");
        n_checks++;
        if (tx_cyc.size() == 2 && (tx_cyc[0] - last_rx_cyc != 3 || tx_cyc[1] - tx_cyc[0] != 3)) begin
            n_fail++;
            $display("FAIL latency: got res=%0d ack=%0d, required 3 3",
                     tx_cyc[0] - last_rx_cyc, tx_cyc[1] - tx_cyc[0]);
        end
    endtask

    task automatic test_bad_chk();
        clear_logs();
        send_frame(8'h0A, 8'h14, 8'h20, 8'h3F);
        wait_idle("bad_chk");
        n_checks++;
        if (tx_log.size() != 1 || tx_log[0] !== 8'h15) begin
            n_fail++;
            $display("FAIL bad_chk tx: got %0d bytes first=%h, required 1 byte 15",
                     tx_log.size(), (tx_log.size() > 0) ? tx_log[0] : 8'h00);
        end
        n_checks++;
        if (err_cnt != 1) begin
            n_fail++;
            $display("FAIL bad_chk err: got %0d pulses, required 1", err_cnt);
        end
        n_checks++;
        if (alu_a !== 8'h0A || alu_b !== 8'h14 || alu_op !== 6'h20) begin
            n_fail++;
            $display("FAIL bad_chk alu regs: got %h %h %h, required 0a 14 20", alu_a, alu_b, alu_op);
        end
    endtask

    task automatic test_timeout();
        clear_logs();
        send_byte(8'hA5);
        send_byte(8'h0A);
        repeat (TO - 2) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b1 || err_cnt != 0) begin
            n_fail++;
            $display("FAIL timeout early: got busy=%b errs=%0d one cycle before expiry, required 1 0", busy, err_cnt);
        end
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout expiry: got busy=%b err=%b, required 0 1", busy, err);
        end
        @(posedge clk); #1;
        check_add_frame("after_timeout");
    endtask

    task automatic test_sync_hunt();
        clear_logs();
        send_byte(8'h33);
        send_frame(8'h05, 8'h03, 8'h22, 8'h24);
        wait_idle("sync_hunt");
        n_checks++;
        if (tx_log.size() != 2 || tx_log[0] !== 8'h02 || tx_log[1] !== 8'h06) begin
            n_fail++;
            $display("FAIL sync_hunt tx: got %0d bytes, required 02 06", tx_log.size());
        end
        n_checks++;
        if (alu_a !== 8'h05 || alu_b !== 8'h03 || alu_op !== 6'h22) begin
            n_fail++;
            $display("FAIL sync_hunt alu regs: got %h %h %h, required 05 03 22", alu_a, alu_b, alu_op);
        end
    endtask

    task automatic test_tx_stall();
        int raise_cyc;
        clear_logs();
        tx_done = 1'b0;
        send_frame(8'h0A, 8'h14, 8'h20, 8'h3E);
        repeat (20) @(posedge clk);
        #1;
        n_checks++;
        if (tx_log.size() != 0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL tx_stall hold: got %0d starts busy=%b, required 0 1", tx_log.size(), busy);
        end
        tx_done = 1'b1;
        raise_cyc = cyc;
        wait_idle("tx_stall");
        n_checks++;
        if (tx_log.size() != 2 || tx_cyc[0] - raise_cyc > 1 || tx_log[0] !== 8'h1E || tx_log[1] !== 8'h06) begin
            n_fail++;
            $display("FAIL tx_stall release: got %0d bytes, required 1e 06 with result start within 1 clk",
                     tx_log.size());
        end
    endtask

    task automatic test_reset_mid();
        send_frame(8'h0A, 8'h14, 8'h20, 8'h3E);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (tx_start !== 1'b0 || tx !== 8'h00 || alu_a !== 8'h00 || alu_b !== 8'h00 ||
            alu_op !== 6'h00 || busy !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid outputs: got start=%b tx=%h a=%h busy=%b, required all 0",
                     tx_start, tx, alu_a, busy);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_add_frame("after_reset");
    endtask

    task automatic test_bad_opcode();
        clear_logs();
        send_frame(8'h01, 8'h02, 8'hE0, 8'hE3);
        wait_idle("bad_op");
        n_checks++;
        if (tx_log.size() != 1 || tx_log[0] !== 8'h15) begin
            n_fail++;
            $display("FAIL bad_op tx: got %0d bytes, required single 15", tx_log.size());
        end
        n_checks++;
        if (err_cnt != 1) begin
            n_fail++;
            $display("FAIL bad_op err: got %0d pulses, required 1", err_cnt);
        end
        n_checks++;
        if (alu_a !== 8'h0A || alu_b !== 8'h14 || alu_op !== 6'h20) begin
            n_fail++;
            $display("FAIL bad_op alu regs: got %h %h %h, required 0a 14 20", alu_a, alu_b, alu_op);
        end
    endtask

    initial begin
        test_reset();
        test_valid_frame();
        test_bad_chk();
        test_timeout();
        test_sync_hunt();
        test_tx_stall();
        test_reset_mid();
        test_bad_opcode();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
